// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for the IF and MEM pipeline stages.
// One access is in flight at a time. MEM has priority, and a saturating
// starvation counter forces an IF grant after STARVE_MAX back-to-back MEM
// grants while IF is waiting.
//
// Handshake: a requester raises *_req with stable fields and holds it until
// it sees its one-cycle *_done pulse. On the memory side, mem_req is high for
// the whole REQ phase. mem_ack accepts the request. mem_rvalid, taken with or
// after mem_ack, completes the access.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_done,
    input  logic          data_req,
    input  logic [3:0]    data_wen,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_done,
    output logic          mem_req,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          stallreq_for_if,
    output logic          stallreq_for_mem,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_MEM    = 1'b1;

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic [2:0] starve_cnt;
    logic       grant_mem;
    logic       grant_if;
    logic       take_rvalid;

    // Arbitration in IDLE and detection of the completing rvalid.
    always_comb begin
        grant_mem   = (state == IDLE) && data_req &&
                      ((starve_cnt < STARVE_LIM) || !inst_req);
        grant_if    = (state == IDLE) && inst_req && !grant_mem;
        take_rvalid = ((state == REQ) && mem_ack && mem_rvalid) ||
                      ((state == WAIT) && mem_rvalid);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. DONE always returns to IDLE without arbitrating.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_mem || grant_if) state_nxt = REQ;
            REQ:  if (mem_ack) state_nxt = mem_rvalid ? DONE : WAIT;
            WAIT: if (mem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        mem_req   = (state == REQ);
        state_dbg = state;
    end

    // Latch the granted request so the port sees stable fields during REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_IF;
            mem_addr  <= '0;
            mem_wen   <= '0;
            mem_wdata <= '0;
        end else if (grant_mem) begin
            owner     <= OWN_MEM;
            mem_addr  <= data_addr;
            mem_wen   <= data_wen;
            mem_wdata <= data_wdata;
        end else if (grant_if) begin
            owner     <= OWN_IF;
            mem_addr  <= inst_addr;
            mem_wen   <= '0;
            mem_wdata <= '0;
        end
    end

    // Starvation counter: counts MEM grants taken while IF waits, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !inst_req)
                starve_cnt <= '0;
            else if (grant_mem && (starve_cnt != 3'd7))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Completion: one-cycle done to the owner, read data captured for reads only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_done <= take_rvalid && (owner == OWN_IF);
            data_done <= take_rvalid && (owner == OWN_MEM);
            if (take_rvalid && (mem_wen == 4'd0)) begin
                if (owner == OWN_MEM) data_rdata <= mem_rdata;
                else                  inst_rdata <= mem_rdata;
            end
        end
    end

    // Stall requests toward the pipeline stall controller.
    always_comb begin
        stallreq_for_if  = inst_req & ~inst_done;
        stallreq_for_mem = data_req & ~data_done;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model decides
// which requester each access belongs to, holds a reference copy of memory,
// and predicts the done and rdata values. A separate responder memory answers
// the port with random ack/rvalid delays.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stallreq_for_if;
    logic        stallreq_for_mem;
    logic [1:0]  state_dbg;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stallreq_for_if(stallreq_for_if),
        .stallreq_for_mem(stallreq_for_mem), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference memory (model) and responder memory (driven by what the DUT presents).
    logic [31:0] ref_mem  [16];
    logic [31:0] resp_mem [16];

    // Requester state.
    bit          inst_pend, data_pend;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_wen;

    // Model state for the access in flight.
    int          starve;
    bit          busy, cur_mem;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wen;
    bit          exp_mreq, exp_done_now;
    logic [31:0] exp_inst_rdata, exp_data_rdata;

    // Responder state.
    int          rphase, ack_left, rv_left, rv_dly;
    logic [31:0] resp_addr;
    logic [3:0]  resp_wen;
    int          fix_ack = -1;
    int          fix_rv  = -1;
    bit          spur;

    int          req_cycles, last_lat, n_if_done, n_d_done;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic drive_reqs();
        inst_req   = inst_pend;
        inst_addr  = if_addr;
        data_req   = data_pend;
        data_addr  = d_addr;
        data_wen   = d_wen;
        data_wdata = d_wdata;
    endtask

    task automatic new_if(input logic [31:0] a);
        inst_pend = 1'b1;
        if_addr   = a;
    endtask

    task automatic new_data(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        data_pend = 1'b1;
        d_addr    = a;
        d_wen     = be;
        d_wdata   = wd;
    endtask

    // One clock cycle: check outputs at the falling edge, then drive the responder.
    task automatic tick();
        @(negedge clk);
        check_eq("mem_req", mem_req, exp_mreq);
        if (mem_req) req_cycles++;
        if (exp_done_now) begin
            if (cur_mem) begin
                if (cur_wen == 4'd0) exp_data_rdata = ref_mem[cur_addr[5:2]];
                else ref_mem[cur_addr[5:2]] = merge(ref_mem[cur_addr[5:2]], cur_wdata, cur_wen);
            end else begin
                exp_inst_rdata = ref_mem[cur_addr[5:2]];
            end
        end
        check_eq("inst_done", inst_done, exp_done_now && !cur_mem);
        check_eq("data_done", data_done, exp_done_now && cur_mem);
        check_eq("inst_rdata", inst_rdata, exp_inst_rdata);
        check_eq("data_rdata", data_rdata, exp_data_rdata);
        check_eq("stall_if", stallreq_for_if, inst_pend && !(exp_done_now && !cur_mem));
        check_eq("stall_mem", stallreq_for_mem, data_pend && !(exp_done_now && cur_mem));
        if (inst_done) n_if_done++;
        if (data_done) n_d_done++;
        if (exp_done_now) begin
            busy         = 1'b0;
            exp_done_now = 1'b0;
            if (cur_mem) data_pend = 1'b0;
            else         inst_pend = 1'b0;
            drive_reqs();
        end
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hFF;
            spur       = 1'b0;
        end
        if (busy && rphase == 0) begin
            check_eq("mem_addr", mem_addr, cur_addr);
            check_eq("mem_wen", {28'd0, mem_wen}, {28'd0, cur_wen});
            if (cur_mem) check_eq("mem_wdata", mem_wdata, cur_wdata);
            if (ack_left == 0) begin
                mem_ack   = 1'b1;
                resp_addr = mem_addr;
                resp_wen  = mem_wen;
                if (mem_wen != 4'd0)
                    resp_mem[mem_addr[5:2]] = merge(resp_mem[mem_addr[5:2]], mem_wdata, mem_wen);
                exp_mreq = 1'b0;
                if (rv_dly == 0) begin
                    mem_rvalid   = 1'b1;
                    if (resp_wen == 4'd0) mem_rdata = resp_mem[resp_addr[5:2]];
                    exp_done_now = 1'b1;
                    rphase       = 2;
                end else begin
                    rphase  = 1;
                    rv_left = rv_dly - 1;
                end
            end else begin
                ack_left--;
            end
        end else if (busy && rphase == 1) begin
            if (rv_left == 0) begin
                mem_rvalid   = 1'b1;
                if (resp_wen == 4'd0) mem_rdata = resp_mem[resp_addr[5:2]];
                exp_done_now = 1'b1;
                rphase       = 2;
            end else begin
                rv_left--;
            end
        end
    endtask

    // Grant decision in an IDLE cycle, from the arbitration rules.
    task automatic arbitrate();
        if (data_pend && (starve < 4 || !inst_pend)) begin
            cur_mem   = 1'b1;
            starve    = inst_pend ? ((starve < 7) ? starve + 1 : 7) : 0;
            cur_addr  = d_addr;
            cur_wen   = d_wen;
            cur_wdata = d_wdata;
        end else if (inst_pend) begin
            cur_mem   = 1'b0;
            starve    = 0;
            cur_addr  = if_addr;
            cur_wen   = 4'd0;
            cur_wdata = 32'd0;
        end else begin
            starve = 0;
            drive_reqs();
            return;
        end
        busy       = 1'b1;
        rphase     = 0;
        exp_mreq   = 1'b1;
        ack_left   = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 3));
        rv_dly     = (fix_rv >= 0) ? fix_rv : int'($urandom_range(0, 2));
        req_cycles = 0;
        drive_reqs();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_wen", {28'd0, mem_wen}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_inst_done", inst_done, 1'b0);
        check_eq("rst_data_done", data_done, 1'b0);
        check_eq("rst_inst_rdata", inst_rdata, 32'd0);
        check_eq("rst_data_rdata", data_rdata, 32'd0);
    endtask

    // Asynchronous reset applied between clock edges; bench model cleared alongside.
    task automatic do_reset();
        rst        = 1'b0;
        inst_pend  = 1'b0;
        data_pend  = 1'b0;
        drive_reqs();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        busy       = 1'b0;
        rphase     = 0;
        exp_mreq   = 1'b0;
        exp_done_now   = 1'b0;
        starve         = 0;
        exp_inst_rdata = 32'd0;
        exp_data_rdata = 32'd0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Grant one access and run it through to the following IDLE cycle.
    task automatic run_txn();
        arbitrate();
        last_lat = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            last_lat++;
        end
        if (busy) begin
            check_eq("done_timeout", 32'd1, 32'd0);
            do_reset();
        end else begin
            tick();
        end
    endtask

    int d0, i0;

    initial begin
        inst_pend = 0; data_pend = 0;
        if_addr = 0; d_addr = 0; d_wen = 0; d_wdata = 0;
        cur_mem = 0; cur_addr = 0; cur_wen = 0; cur_wdata = 0;
        resp_addr = 0; resp_wen = 0; spur = 0;
        n_if_done = 0; n_d_done = 0; req_cycles = 0; last_lat = 0;
        mem_rdata = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            resp_mem[i] = ref_mem[i];
        end
        ref_mem[0]  = 32'h24020005; resp_mem[0] = 32'h24020005;
        ref_mem[2]  = 32'h00000011; resp_mem[2] = 32'h00000011;
        rst = 1'b1;
        drive_reqs();
        mem_ack = 0; mem_rvalid = 0;
        #2;
        do_reset();

        // Single IF read at minimum latency.
        fix_ack = 0; fix_rv = 0;
        new_if(32'h1000);
        run_txn();
        check_eq("if_latency", last_lat, 32'd2);
        check_eq("if_rdata_val", inst_rdata, 32'h24020005);

        // Store with delayed ack and rvalid; data_rdata must not move.
        fix_ack = 3; fix_rv = 2;
        new_data(32'h2004, 4'b1111, 32'hDEADBEEF);
        run_txn();
        check_eq("store_req_cycles", req_cycles, 32'd4);
        check_eq("store_latency", last_lat, 32'd7);

        // Simultaneous requests: MEM first, then IF.
        fix_ack = -1; fix_rv = -1;
        d0 = n_d_done; i0 = n_if_done;
        new_if(32'h1000);
        new_data(32'h2008, 4'b0000, 32'h0);
        run_txn();
        check_eq("simul_first_mem", n_d_done - d0, 32'd1);
        check_eq("simul_first_no_if", n_if_done - i0, 32'd0);
        check_eq("simul_load_val", data_rdata, 32'h11);
        run_txn();
        check_eq("simul_then_if", n_if_done - i0, 32'd1);

        // Continuous MEM traffic with IF pending: four MEM grants then IF.
        d0 = n_d_done; i0 = n_if_done;
        new_if($urandom & 32'hFFFF_FFFC);
        for (int k = 0; k < 8 && inst_pend; k++) begin
            new_data($urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                     $urandom);
            run_txn();
        end
        check_eq("starve_mem_grants", n_d_done - d0, 32'd4);
        check_eq("starve_if_grants", n_if_done - i0, 32'd1);
        d0 = n_d_done;
        new_if($urandom & 32'hFFFF_FFFC);
        new_data($urandom & 32'hFFFF_FFFC, 4'd0, 32'd0);
        run_txn();
        check_eq("starve_cleared_mem_wins", n_d_done - d0, 32'd1);

        // Spurious rvalid in IDLE is ignored.
        inst_pend = 0; data_pend = 0; drive_reqs();
        tick();
        spur = 1'b1;
        d0 = n_d_done; i0 = n_if_done;
        repeat (4) tick();
        check_eq("spur_no_done", (n_d_done - d0) + (n_if_done - i0), 32'd0);

        // Asynchronous reset while waiting for rvalid.
        fix_ack = 0; fix_rv = 20;
        data_pend = 0;
        new_data(32'h0000_0030, 4'd0, 32'd0);
        arbitrate();
        repeat (2) tick();
        check_eq("wait_state", {30'd0, state_dbg}, 32'd2);
        #2;
        do_reset();
        fix_ack = -1; fix_rv = -1;
        repeat (5) tick();

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            if (!inst_pend && $urandom_range(0, 2) != 0)
                new_if($urandom & 32'hFFFF_FFFC);
            if (!data_pend && $urandom_range(0, 3) != 0)
                new_data($urandom & 32'hFFFF_FFFC,
                         $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
            if (!inst_pend && !data_pend)
                new_if($urandom & 32'hFFFF_FFFC);
            run_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
